// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronise, debounce and escrow the coin chute sensors into one-cycle coin pulses.
// Define COIN_TOTAL_EN to add the saturating total_rs rupee counter output.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_hundred,
    input  logic raw_fifty,
    input  logic busy,
    output logic hundred_in,
    output logic fifty_in,
    output logic coin_reject,
    output logic escrow_full
`ifdef COIN_TOTAL_EN
    ,
    output logic [15:0] total_rs
`endif
);
    typedef enum logic [2:0] {IDLE, QUAL_H, QUAL_F, REJECT, RELEASE} state_t;
    localparam logic [CNT_W-1:0] DC = CNT_W'(DEBOUNCE_CYCLES);
    state_t state;
    logic [1:0] sync_h, sync_f;
    logic [CNT_W-1:0] cnt;
    logic esc_hundred;
    logic s_h, s_f, emit, own, other;
    assign s_h = sync_h[1];
    assign s_f = sync_f[1];
    assign emit = escrow_full & ~busy;
    assign own = (state == QUAL_H) ? s_h : s_f;
    assign other = (state == QUAL_H) ? s_f : s_h;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            sync_h <= '0;
            sync_f <= '0;
            cnt <= '0;
            esc_hundred <= 1'b0;
            hundred_in <= 1'b0;
            fifty_in <= 1'b0;
            coin_reject <= 1'b0;
            escrow_full <= 1'b0;
        end else begin
            sync_h <= {sync_h[0], raw_hundred};
            sync_f <= {sync_f[0], raw_fifty};
            hundred_in <= emit & esc_hundred;
            fifty_in <= emit & ~esc_hundred;
            coin_reject <= 1'b0;
            if (emit) escrow_full <= 1'b0;
            case (state)
                IDLE:
                    if (s_h & s_f) begin
                        state <= REJECT;
                        coin_reject <= 1'b1;
                    end else if (s_h | s_f) begin
                        state <= s_h ? QUAL_H : QUAL_F;
                        cnt <= CNT_W'(1);
                    end
                QUAL_H, QUAL_F:
                    if (other) begin
                        state <= REJECT;
                        coin_reject <= 1'b1;
                    end else if (!own) begin
                        state <= IDLE;
                    end else if (cnt == DC) begin
                        // a draining coin frees the escrow on this very edge
                        state <= RELEASE;
                        if (escrow_full & ~emit) begin
                            coin_reject <= 1'b1;
                        end else begin
                            escrow_full <= 1'b1;
                            esc_hundred <= (state == QUAL_H);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                default:
                    if (!s_h & !s_f) state <= IDLE;
            endcase
        end
    end
`ifdef COIN_TOTAL_EN
    logic [16:0] sum;
    assign sum = {1'b0, total_rs} + (esc_hundred ? 17'd100 : 17'd50);
    always_ff @(posedge clk) begin
        if (!reset) total_rs <= '0;
        else if (emit) total_rs <= sum[16] ? 16'hFFFF : sum[15:0];
    end
`endif
endmodule
